// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing helpers shared by the UART receiver
// and transmitter.
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_REC_BYTE = 3'd2,
      S_STOP     = 3'd3,
      S_DATA     = 3'd4
   } state_t;

   // Width of the per-bit clock counter
   localparam int CNT_W = 16;

   // Clocks per bit: CLK_FRE is in MHz; integer division truncates
   function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                              input int unsigned baud);
      return (clk_fre * 32'd1000000) / baud;
   endfunction

   // Clocks to mid-bit
   function automatic int unsigned calc_half(input int unsigned clk_fre,
                                             input int unsigned baud);
      return calc_cycle(clk_fre, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL selects the value both flops take in reset (1 for an idle-high line).
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready byte output.
// Optional feature: define UART_RX_FERR_EN to add the frame_err output; a
// zero stop bit then pulses frame_err for one cycle and drops the byte.
// Without it the byte is delivered whatever the stop bit holds.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FRE   = 50,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   input  logic       rx_data_ready
`ifdef UART_RX_FERR_EN
   ,
   output logic       frame_err
`endif
);

   localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
   localparam int unsigned HALF  = calc_half(CLK_FRE, BAUD_RATE);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYCLE - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_bits;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_prev;
   // Fills with ones after reset; once r_live[2] is set, both the current and
   // previous synchronized samples come from the real line rather than from
   // reset values, so a line held low through reset cannot fake an edge.
   logic [2:0]       r_live;

   logic             w_rx;
   logic             w_fall;
   logic             w_mid;
   logic             w_stop_bad;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rx_pin),
      .o_q   (w_rx)
   );

   assign w_fall = r_live[2] & r_prev & ~w_rx;
   assign w_mid  = (r_cnt == HALF_LAST);

`ifdef UART_RX_FERR_EN
   assign w_stop_bad = ~w_rx;
`else
   assign w_stop_bad = 1'b0;
`endif

   // Receive FSM: start detect, mid-bit sampling, stop check, output hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_bits    <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_prev    <= 1'b1;
         r_live    <= '0;
      end else begin
         r_prev <= w_rx;
         r_live <= {r_live[1:0], 1'b1};
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_fall) r_state <= S_START;
            end
            S_START: begin
               if (w_mid && w_rx) begin
                  // line back high at mid start bit: glitch
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CYC_LAST) begin
                  r_state <= S_REC_BYTE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_REC_BYTE: begin
               if (w_mid) r_bits[r_bit_cnt] <= w_rx;
               if (r_cnt == CYC_LAST) begin
                  r_cnt     <= '0;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               // leave at mid stop bit so a back-to-back start edge is seen
               if (w_mid) begin
                  r_cnt <= '0;
                  if (w_stop_bad) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_data  <= r_bits;
                     r_valid <= 1'b1;
                     r_state <= S_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               r_cnt <= '0;
               if (rx_data_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef UART_RX_FERR_EN
   logic r_ferr;

   // One-cycle pulse when the mid stop-bit sample is low
   always_ff @(posedge clk) begin
      if (!rst_n) r_ferr <= 1'b0;
      else        r_ferr <= (r_state == S_STOP) && w_mid && w_stop_bad;
   end

   assign frame_err = r_ferr;
`endif

   assign rx_data       = r_data;
   assign rx_data_valid = r_valid;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CYCLE=10 clocks per bit.
// Expected bytes come from a frame-level model: a frame is delivered unless
// it was a glitch, was cut by reset, arrived while a byte was held, or (with
// UART_RX_FERR_EN) had a zero stop bit.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CYC = 10;
`ifdef UART_RX_FERR_EN
   localparam logic FERR = 1'b1;
`else
   localparam logic FERR = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic       rx_data_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_data_valid;
`ifdef UART_RX_FERR_EN
   logic       frame_err;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int vld_total = 0;
   int rise_cyc = 0;
   int ferr_pulses = 0;
   int ferr_cycles = 0;
   logic vld_d = 1'b0;
   logic ferr_d = 1'b0;
   logic [7:0] got[$];
   logic [7:0] expq[$];
   vec_t tbl[8];
   int bad;
   int t0, v0, p0, lat;
   logic [7:0] rd;
   logic rs;
   int rg;

   always #5 clk = ~clk;

   uart_rx #(.CLK_FRE(1), .BAUD_RATE(100000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_pin        (rx_pin),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready)
`ifdef UART_RX_FERR_EN
      ,
      .frame_err     (frame_err)
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs half a cycle away from the active edge
   always @(negedge clk) begin
      if (rx_data_valid) vld_total <= vld_total + 1;
      if (rx_data_valid && !vld_d) rise_cyc <= cyc;
      vld_d <= rx_data_valid;
      if (rx_data_valid && rx_data_ready) got.push_back(rx_data);
`ifdef UART_RX_FERR_EN
      if (frame_err) ferr_cycles <= ferr_cycles + 1;
      if (frame_err && !ferr_d) ferr_pulses <= ferr_pulses + 1;
      ferr_d <= frame_err;
`endif
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic check_sb(input string n);
      chk({n, "_count"}, 64'(got.size()), 64'(expq.size()));
      if (got.size() == expq.size() && got.size() > 0)
         chk({n, "_data"}, 64'(got[$]), 64'(expq[$]));
   endtask

   // Caller is at a negedge; returns at a negedge. Start, 8 data LSB first,
   // stop, then gap idle bit times.
   task automatic send_byte(input logic [7:0] d, input logic stop, input int gap);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_pin = fr[i];
         repeat (CYC) @(negedge clk);
      end
      rx_pin = 1'b1;
      repeat (gap * CYC) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'hA3, 1'b1, 0, 1'b1, 8'hA3, 1'b0};
      tbl[1] = '{8'h0F, 1'b1, 2, 1'b1, 8'h0F, 1'b0};
      tbl[2] = '{8'h00, 1'b1, 1, 1'b1, 8'h00, 1'b0};
      tbl[3] = '{8'hFF, 1'b1, 1, 1'b1, 8'hFF, 1'b0};
      tbl[4] = '{8'hC4, 1'b0, 2, ~FERR, 8'hC4, FERR};
      tbl[5] = '{8'h80, 1'b1, 1, 1'b1, 8'h80, 1'b0};
      tbl[6] = '{8'h01, 1'b1, 0, 1'b1, 8'h01, 1'b0};
      tbl[7] = '{8'h7E, 1'b1, 2, 1'b1, 8'h7E, 1'b0};

      // reset state
      rst_n = 1'b0; rx_pin = 1'b1; rx_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(rx_data_valid), 64'd0);
      chk("rst_data", 64'(rx_data), 64'd0);
`ifdef UART_RX_FERR_EN
      chk("rst_ferr", 64'(frame_err), 64'd0);
`endif
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // single frame: one-cycle valid, latency ~9.5 bits plus sync
      v0 = vld_total; t0 = cyc;
      send_byte(8'h55, 1'b1, 3);
      expq.push_back(8'h55);
      check_sb("b55");
      chk("b55_vld_cycles", 64'(vld_total - v0), 64'd1);
      lat = rise_cyc - t0;
      checks++;
      if (lat < 92 || lat > 102) begin
         failures++;
         $display("FAIL b55_latency: got %0d expected 92..102", lat);
      end
      chk("b55_data_hold", 64'(rx_data), 64'h55);

      // 3-clock low glitch
      rx_pin = 1'b0;
      repeat (3) @(negedge clk);
      rx_pin = 1'b1;
      repeat (150) @(negedge clk);
      check_sb("glitch");

      // table: back-to-back frames and stop-bit cases
      for (int i = 0; i < 8; i++) begin
         p0 = ferr_pulses;
         send_byte(tbl[i].data, tbl[i].stop, tbl[i].gap);
         if (tbl[i].exp_valid) expq.push_back(tbl[i].exp_data);
         check_sb($sformatf("tbl%0d", i));
`ifdef UART_RX_FERR_EN
         chk($sformatf("tbl%0d_ferr", i), 64'(ferr_pulses - p0), 64'(tbl[i].exp_ferr));
`endif
      end

      // random frames against the frame-level model
      for (int i = 0; i < 10; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         rg = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_byte(rd, rs, rg);
         if (rs || !FERR) expq.push_back(rd);
         check_sb($sformatf("rnd%0d", i));
      end

      // hold with ready low; a second frame arrives meanwhile and is lost
      rx_data_ready = 1'b0;
      send_byte(8'h81, 1'b1, 0);
      bad = 0;
      fork
         send_byte(8'h5A, 1'b1, 3);
         begin
            for (int k = 0; k < 120; k++) begin
               if (!(rx_data_valid === 1'b1 && rx_data === 8'h81)) bad++;
               @(negedge clk);
            end
         end
      join
      chk("hold_stable", 64'(bad), 64'd0);
      check_sb("hold_no_xfer");
      @(posedge clk); #1;
      rx_data_ready = 1'b1;
      @(posedge clk); #1;
      expq.push_back(8'h81);
      check_sb("hold_xfer");
      chk("hold_valid_drop", 64'(rx_data_valid), 64'd0);
      @(negedge clk);
      repeat (150) @(negedge clk);
      check_sb("hold_second_dropped");

      // reset during bit 4 of a frame
      fork
         send_byte(8'hF0, 1'b1, 3);
         begin
            repeat (52) @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            chk("midrst_valid", 64'(rx_data_valid), 64'd0);
            chk("midrst_data", 64'(rx_data), 64'd0);
`ifdef UART_RX_FERR_EN
            chk("midrst_ferr", 64'(frame_err), 64'd0);
`endif
            rst_n = 1'b1;
         end
      join
      repeat (150) @(negedge clk);
      check_sb("midrst_abandon");

      // line held low through reset must not start a frame
      rx_pin = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      rx_pin = 1'b1;
      repeat (150) @(negedge clk);
      check_sb("low_thru_rst");

      // clean frame after reset
      send_byte(8'h3C, 1'b1, 3);
      expq.push_back(8'h3C);
      check_sb("after_rst");

      chk("total_count", 64'(got.size()), 64'(expq.size()));
`ifdef UART_RX_FERR_EN
      chk("ferr_one_cycle", 64'(ferr_cycles), 64'(ferr_pulses));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
